// File: rtl/timing_stim_pkg.sv
// Shared definitions for the timing stimulus generator: FSM state encoding,
// the margin clamp helper and phase-counter width helpers.
package timing_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int DIV_DEFAULT = 16;
  localparam int PHW_DEFAULT = $clog2(DIV_DEFAULT);

  // Width of a counter that spans 0..div-1.
  function automatic int ph_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // Saturate v into the closed range [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/stim_phase_ctr.sv
// Phase counter for one strobe period. It exposes the registered phase, the
// phase the next clock edge will load, and decodes of that next phase so
// the top can register its outputs aligned with the phase they belong to.
module stim_phase_ctr
  import timing_stim_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int PW  = PHW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] launch_ph,
  input  logic [PW-1:0] inval_ph,
  output logic [PW-1:0] ph,
  output logic [PW-1:0] ph_nxt,
  output logic          at_launch,
  output logic          at_rise,
  output logic          at_inval
);

  localparam logic [PW-1:0] LAST_PH = PW'(DIV - 1);
  localparam logic [PW-1:0] RISE_PH = PW'(DIV / 2);

  // Next phase: advance and wrap while enabled, otherwise park at zero.
  always_comb begin
    ph_nxt = '0;
    if (en) begin
      ph_nxt = (ph == LAST_PH) ? '0 : ph + PW'(1);
    end
  end

  assign at_launch = (ph_nxt == launch_ph);
  assign at_rise   = (ph_nxt == RISE_PH);
  assign at_inval  = (ph_nxt == inval_ph);

  // Phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= '0;
    end else begin
      ph <= ph_nxt;
    end
  end

endmodule

// File: rtl/timing_stim_gen.sv
// Strobe/data stimulus transmitter with programmable setup and hold margins.
// It also predicts the setup/hold check result at every strobe rise and
// mirrors it on viol_setup_o / viol_hold_o / notifier_o.
//
// Data handshake: data_ack_o is a pull strobe. data_i is sampled at the clock
// edge that raises data_ack_o (the same edge that loads d_o), so the producer
// must hold the next word on data_i before that edge and may advance it at
// any time while data_ack_o is high.
//
// Every output is registered from the next-state/next-phase values, so in
// any cycle the outputs describe the phase held in the phase register.
module timing_stim_gen
  import timing_stim_pkg::*;
#(
  parameter int DIV  = 16,
  parameter int W    = 8,
  parameter int OFFW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      count_i,
  input  logic [OFFW-1:0] setup_i,
  input  logic [OFFW-1:0] hold_i,
  input  logic [OFFW-1:0] setup_lim_i,
  input  logic [OFFW-1:0] hold_lim_i,
  input  logic [W-1:0]    data_i,
  output logic            data_ack_o,
  output logic            sclk_o,
  output logic [W-1:0]    d_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            viol_setup_o,
  output logic            viol_hold_o,
  output logic            notifier_o,
  output state_t          dbg_state
);

  localparam int R  = DIV / 2;
  localparam int PW = ph_width(DIV);
  localparam logic [PW-1:0] R_PH    = PW'(R);
  localparam logic [PW-1:0] LAST_PH = PW'(DIV - 1);

  state_t          state_q;
  state_t          state_nxt;
  logic [7:0]      cnt_q;
  logic [PW-1:0]   su_q;
  logic [PW-1:0]   ho_q;
  logic [OFFW-1:0] sl_q;
  logic [OFFW-1:0] hl_q;

  logic [PW-1:0]   su_in;
  logic [PW-1:0]   ho_in;
  logic [PW-1:0]   su_use;
  logic [PW-1:0]   launch_ph;
  logic [PW-1:0]   inval_ph;
  logic [PW-1:0]   ph;
  logic [PW-1:0]   ph_nxt;
  logic            en;
  logic            at_launch;
  logic            at_rise;
  logic            at_inval;
  logic            running_nxt;
  logic            launch;
  logic            inval;
  logic            chk;
  logic            vs;
  logic            vh;

  // Clamped margins taken straight from the inputs, used on the start edge.
  assign su_in = PW'(clamp(int'(setup_i), 1, R));
  assign ho_in = PW'(clamp(int'(hold_i), 1, R - 1));

  // With su = R the first launch lands on phase 0, i.e. on the start edge
  // itself, before su_q has been loaded; use the live value there.
  assign su_use    = (state_q == IDLE) ? su_in : su_q;
  assign launch_ph = R_PH - su_use;
  assign inval_ph  = R_PH + ho_q;

  assign en = (state_q == RUN) || (state_q == DRAIN);

  stim_phase_ctr #(
    .DIV (DIV),
    .PW  (PW)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .launch_ph (launch_ph),
    .inval_ph  (inval_ph),
    .ph        (ph),
    .ph_nxt    (ph_nxt),
    .at_launch (at_launch),
    .at_rise   (at_rise),
    .at_inval  (at_inval)
  );

  // Next-state decode for the burst FSM.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = (count_i != 8'd0) ? RUN : FIN;
      RUN:     if (at_rise && (cnt_q == 8'd1)) state_nxt = DRAIN;
      DRAIN:   if (ph == LAST_PH) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign running_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
  assign launch      = (state_nxt == RUN) && at_launch;
  assign inval       = running_nxt && at_inval;
  assign chk         = (state_q == RUN) && at_rise;
  // A zero limit can never exceed a clamped margin (>= 1), so it never flags.
  assign vs          = chk && (int'(su_q) < int'(sl_q));
  assign vh          = chk && (int'(ho_q) < int'(hl_q));

  // Burst FSM, captured burst parameters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      su_q         <= '0;
      ho_q         <= '0;
      sl_q         <= '0;
      hl_q         <= '0;
      data_ack_o   <= 1'b0;
      sclk_o       <= 1'b0;
      d_o          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      viol_setup_o <= 1'b0;
      viol_hold_o  <= 1'b0;
      notifier_o   <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if ((state_q == IDLE) && start) begin
        cnt_q <= count_i;
        su_q  <= su_in;
        ho_q  <= ho_in;
        sl_q  <= setup_lim_i;
        hl_q  <= hold_lim_i;
      end else if (chk) begin
        cnt_q <= cnt_q - 8'd1;
      end

      sclk_o     <= running_nxt && (ph_nxt >= R_PH);
      data_ack_o <= launch;
      if (launch) begin
        d_o <= data_i;
      end else if (inval) begin
        d_o <= ~d_o;
      end

      busy_o       <= (state_nxt != IDLE);
      done_o       <= (state_nxt == FIN);
      viol_setup_o <= vs;
      viol_hold_o  <= vh;
      if (vs || vh) begin
        notifier_o <= ~notifier_o;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_timing_stim_gen.sv
// Directed bench for timing_stim_gen: a table of bursts with hand-computed
// launch/invalidate phases and violation flags, plus a mid-burst reset.
module tb_timing_stim_gen;
  import timing_stim_pkg::*;

  localparam int DIV  = 16;
  localparam int W    = 8;
  localparam int OFFW = 4;
  localparam int R    = DIV / 2;

  logic            clk;
  logic            rst;
  logic            start;
  logic [7:0]      count_i;
  logic [OFFW-1:0] setup_i;
  logic [OFFW-1:0] hold_i;
  logic [OFFW-1:0] setup_lim_i;
  logic [OFFW-1:0] hold_lim_i;
  logic [W-1:0]    data_i;
  logic            data_ack_o;
  logic            sclk_o;
  logic [W-1:0]    d_o;
  logic            busy_o;
  logic            done_o;
  logic            viol_setup_o;
  logic            viol_hold_o;
  logic            notifier_o;
  state_t          dbg_state;

  int checks   = 0;
  int failures = 0;
  int cur_k    = -1;

  logic [W-1:0] exp_d;
  logic         exp_notif;

  typedef struct {
    logic [3:0] setup;
    logic [3:0] hold;
    logic [3:0] slim;
    logic [3:0] hlim;
    logic [7:0] count;
    logic [7:0] w0;
    logic [7:0] w1;
    int         launch_ph;
    int         inval_ph;
    logic       vs;
    logic       vh;
  } vec_t;

  vec_t vecs[7];

  timing_stim_gen #(
    .DIV  (DIV),
    .W    (W),
    .OFFW (OFFW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .count_i      (count_i),
    .setup_i      (setup_i),
    .hold_i       (hold_i),
    .setup_lim_i  (setup_lim_i),
    .hold_lim_i   (hold_lim_i),
    .data_i       (data_i),
    .data_ack_o   (data_ack_o),
    .sclk_o       (sclk_o),
    .d_o          (d_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .viol_setup_o (viol_setup_o),
    .viol_hold_o  (viol_hold_o),
    .notifier_o   (notifier_o),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, cur_k, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   data_ack_o,   0);
    chk({tag, "_sclk"},  sclk_o,       0);
    chk({tag, "_d"},     d_o,          0);
    chk({tag, "_busy"},  busy_o,       0);
    chk({tag, "_done"},  done_o,       0);
    chk({tag, "_vs"},    viol_setup_o, 0);
    chk({tag, "_vh"},    viol_hold_o,  0);
    chk({tag, "_notif"}, notifier_o,   0);
    chk({tag, "_state"}, dbg_state,    IDLE);
  endtask

  task automatic drive_start(input vec_t v);
    data_i      = v.w0;
    setup_i     = v.setup;
    hold_i      = v.hold;
    setup_lim_i = v.slim;
    hold_lim_i  = v.hlim;
    count_i     = v.count;
    start       = 1'b1;
    tick;
    // Scramble the burst inputs: the running burst must not see them.
    start       = 1'b0;
    setup_i     = ~v.setup;
    hold_i      = ~v.hold;
    setup_lim_i = ~v.slim;
    hold_lim_i  = ~v.hlim;
    count_i     = v.count + 8'd3;
  endtask

  // Run one burst from the table and check every cycle of it.
  task automatic run_vec(input int idx);
    vec_t       v;
    int         n;
    int         ph;
    int         widx;
    logic       in_run;
    logic       exp_ack;
    logic       exp_chk;
    logic [7:0] words[2];
    v        = vecs[idx];
    n        = int'(v.count) * DIV;
    widx     = 0;
    words[0] = v.w0;
    words[1] = v.w1;
    drive_start(v);
    for (int k = 0; k <= n; k++) begin
      cur_k   = k;
      ph      = k % DIV;
      in_run  = (k < n);
      exp_ack = in_run && (ph == v.launch_ph);
      if (exp_ack) exp_d = words[k / DIV];
      if (in_run && (ph == v.inval_ph)) exp_d = ~exp_d;
      exp_chk = in_run && (ph == R);
      if (exp_chk && (v.vs || v.vh)) exp_notif = ~exp_notif;
      chk("busy",  busy_o,       1);
      chk("done",  done_o,       (k == n));
      chk("sclk",  sclk_o,       in_run && (ph >= R));
      chk("ack",   data_ack_o,   exp_ack);
      chk("d",     d_o,          exp_d);
      chk("vs",    viol_setup_o, exp_chk && v.vs);
      chk("vh",    viol_hold_o,  exp_chk && v.vh);
      chk("notif", notifier_o,   exp_notif);
      if (data_ack_o) begin
        widx++;
        data_i = (widx == 1) ? v.w1 : 8'h00;
      end
      // A start pulse mid-burst must be ignored.
      start = (k == 3);
      tick;
    end
    start = 1'b0;
    cur_k = n + 1;
    chk("post_busy",  busy_o,    0);
    chk("post_done",  done_o,    0);
    chk("post_state", dbg_state, IDLE);
    chk("post_d",     d_o,       exp_d);
  endtask

  initial begin
    //               setup hold slim hlim count  w0     w1  launch inval vs vh
    vecs[0] = '{4'd3,  4'd2,  4'd2, 4'd2, 8'd2, 8'hA5, 8'h3C, 5, 10, 1'b0, 1'b0};
    vecs[1] = '{4'd1,  4'd2,  4'd2, 4'd2, 8'd2, 8'h11, 8'h22, 7, 10, 1'b1, 1'b0};
    vecs[2] = '{4'd1,  4'd1,  4'd4, 4'd4, 8'd2, 8'hC3, 8'h96, 7, 9,  1'b1, 1'b1};
    vecs[3] = '{4'd0,  4'd15, 4'd0, 4'd0, 8'd2, 8'hF0, 8'h0F, 7, 15, 1'b0, 1'b0};
    vecs[4] = '{4'd5,  4'd3,  4'd1, 4'd1, 8'd0, 8'h77, 8'h88, 3, 11, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd0,  4'd9, 4'd1, 8'd2, 8'h5A, 8'hE1, 0, 9,  1'b1, 1'b0};
    vecs[6] = '{4'd4,  4'd3,  4'd4, 4'd5, 8'd1, 8'hB4, 8'h00, 4, 11, 1'b0, 1'b1};

    rst         = 1'b0;
    start       = 1'b0;
    count_i     = '0;
    setup_i     = '0;
    hold_i      = '0;
    setup_lim_i = '0;
    hold_lim_i  = '0;
    data_i      = '0;
    exp_d       = '0;
    exp_notif   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    tick;
    chk_all_zero("idle");

    // Table of bursts.
    for (int i = 0; i < 7; i++) begin
      run_vec(i);
      tick;
    end

    // Mid-burst reset at phase 12 of the first pulse.
    drive_start(vecs[0]);
    repeat (12) tick;
    cur_k = 12;
    chk("pre_rst_sclk", sclk_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("held_rst");
    rst       = 1'b1;
    exp_d     = '0;
    exp_notif = 1'b0;
    tick;
    chk_all_zero("after_rst");

    // A fresh burst after the abort must run cleanly.
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timing_stim_gen.md
# timing_stim_gen

Cycle-based stimulus transmitter that drives a strobe (`sclk_o`) and a data bus (`d_o`) with programmable setup and hold margins. It is used on the driving side of the timing-check regression, facing a DUT whose `$setup`/`$hold` checks toggle a notifier. The block computes the expected check result for every strobe edge and mirrors it on its own flags and notifier, so the bench compares the DUT notifier against `notifier_o`. It runs on a fast reference clock; all margins are whole `clk` cycles.

## Interface
Parameters:
- `DIV`, 16: `sclk_o` period in `clk` cycles; even, ≥4. `R = DIV/2` is the rise phase.
- `W`, 8: data width.
- `OFFW`, 4: width of margin/limit inputs.

Ports:
- `clk`  in  1  reference clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin burst when idle.
- `count_i`  in  8  number of strobe pulses.
- `setup_i`  in  OFFW  data-valid cycles before rise.
- `hold_i`  in  OFFW  data-held cycles after rise.
- `setup_lim_i`  in  OFFW  required setup.
- `hold_lim_i`  in  OFFW  required hold.
- `data_i`  in  W  next word, sampled on `data_ack_o`.
- `data_ack_o`  out  1  word consumed this cycle.
- `sclk_o`  out  1  generated strobe.
- `d_o`  out  W  generated data.
- `busy_o`  out  1  burst in progress.
- `done_o`  out  1  one-cycle burst completion pulse.
- `viol_setup_o`  out  1  one-cycle expected setup-violation pulse.
- `viol_hold_o`  out  1  one-cycle expected hold-violation pulse.
- `notifier_o`  out  1  toggles per violating edge.

## Operation
- FSM states:
  - IDLE → RUN on `start` with `count_i`≠0.
  - IDLE → FIN on `start` with `count_i`=0.
  - RUN → DRAIN after the `count`-th rise.
  - DRAIN → FIN at phase wrap.
  - FIN → IDLE after one cycle.
- `start` is ignored outside IDLE.
- The `start` cycle captures `count_i`, the margins and the limits into registers. Later changes to these inputs have no effect on the running burst.
- Clamps:
  - `su = min(max(setup_i,1),R)`.
  - `ho = min(max(hold_i,1),R-1)`.
- A phase counter `ph` runs 0..DIV-1 and wraps. `sclk_o = (ph ≥ R)` in RUN/DRAIN, else 0.
- Launch at `ph = R-su` (RUN only): `d_o ← data_i`, with `data_ack_o` high in the same cycle.
- Invalidate at `ph = R+ho`: `d_o ← ~d_o`.
- Check at `ph = R`:
  - `viol_setup_o = (su < setup_lim)`.
  - `viol_hold_o = (ho < hold_lim)`.
  - `notifier_o` toggles once if either is set. Both set still gives a single toggle.
- DRAIN performs no launch. Strobe completes the period low and `d_o` holds its last value.
- `done_o` is high in FIN. `busy_o` is high in RUN, DRAIN and FIN.
- A limit of 0 never flags.

## Timing
- Reset values: state IDLE, `ph=0`, all outputs 0 including `d_o` and `notifier_o`.
- Reset mid-burst aborts immediately to the reset values. No `done_o` is produced.
- Start latency: `start` sampled in cycle T; `ph=0` in cycle T+1.
- First rise: cycle T+1+R. First launch: cycle T+1+R-su.
- Burst length: `busy_o` high for `count*DIV+1` cycles. `done_o` in the last of these cycles.
- `count_i`=0: `done_o` at T+1, no strobe, `busy_o` high for 1 cycle.
- All outputs registered; no combinational input-to-output path.

## Structure
- Shared package `timing_stim_pkg` holds:
  - FSM state enum (IDLE, RUN, DRAIN, FIN).
  - Clamp function.
  - Phase-width constant `$clog2(DIV)`.
- One natural sub-module, `stim_phase_ctr`: phase counter with wrap and decoded `at_launch`, `at_rise` and `at_inval` strobes. The FSM and datapath stay in the top.

## Test plan
- Clean pass: DIV=16, su=3, ho=2, limits 2/2, count=2, data A5,3C.
  - Launch at ph5, rise at ph8, invert at ph10 in both periods.
  - No violations; notifier stays 0; `done_o` 33 cycles after start.
- Setup violation: su=1, limit 2 → `viol_setup_o` at each rise and `notifier_o` toggles 0→1→0 over two pulses.
- Both violate: su=1/ho=1, limits 4/4 → both flags pulse together and `notifier_o` toggles once per edge.
- Clamp: setup_i=0, hold_i=15 → su=1, ho=7; invert at ph15, launch at next ph7.
- `count_i`=0 → `done_o` at T+1, `sclk_o` stays 0.
- Reset mid-burst: assert `rst` at ph12 of pulse 1 → all outputs 0 immediately. A new `start` runs cleanly.
